dmem_access_ctrl: RTL and testbench

MEM-stage data-memory access controller. Consumes the store byte enables and the ALU effective address from the MEM stage. Runs a req/ack transaction with a variable-latency data memory, and stalls the pipeline until the transaction completes. Returns load data extracted and extended per opcode, and flags misaligned accesses and bus timeouts.

---
 rtl/dmem_access_ctrl_pkg.sv | 39 +++
 rtl/dmem_access_ctrl_load_ext.sv | 28 ++
 rtl/dmem_access_ctrl.sv | 128 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// load/store opcodes, FSM state encoding and the misalignment predicate.
package dmem_access_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Words need both low address bits clear, halfwords only bit 0.
    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
        logic mis;
        case (op)
            OP_LW, OP_SW:          mis = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH:  mis = off[0];
            default:               mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_ext.sv
// Load data extraction: selects the addressed byte/halfword from a little-endian
// word and sign- or zero-extends it. Purely combinational.
module dmem_access_ctrl_load_ext
    import dmem_access_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        byte_sel = word[{byte_off, 3'b000} +: 8];
        half_sel = byte_off[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'h0, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'h0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: req/ack handshake with a
// variable-latency memory, pipeline stall, load extension, misalign and timeout flags.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [5:0]  OP,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       lat_op;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [3:0]       lat_be;

    logic        handled;
    logic        misalign;
    logic        accept;
    logic        timeout;
    logic [31:0] ext_data;

    assign handled  = is_load(OP) || is_store(OP);
    assign misalign = misaligned(OP, addr[1:0]);
    assign accept   = req_valid && handled && !misalign;
    assign timeout  = (cnt == CNT_W'(TIMEOUT - 1));

    // Stall must freeze the pipeline in the acceptance cycle itself, and fall with reset.
    assign stall = !rst && ((state == ST_BUSY) || (state == ST_IDLE && accept));

    always_comb begin
        mem_we    = is_store(lat_op);
        mem_addr  = {lat_addr[31:2], 2'b00};
        mem_be    = is_store(lat_op) ? lat_be : 4'b1111;
        case (lat_op)
            OP_SB:   mem_wdata = {4{lat_wdata[7:0]}};
            OP_SH:   mem_wdata = {2{lat_wdata[15:0]}};
            default: mem_wdata = lat_wdata;
        endcase
    end

    dmem_access_ctrl_load_ext u_load_ext (
        .op       (lat_op),
        .byte_off (lat_addr[1:0]),
        .word     (mem_rdata),
        .result   (ext_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            lat_op      <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_be      <= '0;
            mem_req     <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            addr_err    <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            addr_err    <= 1'b0;
            bus_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_op    <= OP;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        lat_be    <= be;
                        mem_req   <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_BUSY;
                    end else if (req_valid && handled && misalign) begin
                        addr_err  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    // An ack on the final allowed cycle still completes normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_RESP;
                        if (is_load(lat_op)) begin
                            rdata       <= ext_data;
                            rdata_valid <= 1'b1;
                        end
                    end else if (timeout) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        rdata   <= '0;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: a cycle-timeline model of each
// transaction is compared against the DUT on every falling clock edge.
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100, LHU = 6'b100101;
    localparam logic [5:0] SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
    localparam logic [5:0] ADDI = 6'b001000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [5:0]  OP;
    logic [31:0] addr, wdata, mem_rdata;
    logic [3:0]  be;
    logic        mem_ack;
    logic        stall, rdata_valid, addr_err, bus_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    dmem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .OP(OP), .addr(addr),
        .wdata(wdata), .be(be), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .addr_err(addr_err), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected per-cycle outputs, set by the stimulus alongside the inputs.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_rvalid, exp_aerr, exp_berr, exp_we;
    logic [31:0] exp_addr, exp_wdata, m_rdata;
    logic [3:0]  exp_be;

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", stall, exp_stall);
            check("mem_req", mem_req, exp_req);
            check("rdata_valid", rdata_valid, exp_rvalid);
            check("addr_err", addr_err, exp_aerr);
            check("bus_err", bus_err, exp_berr);
            check("rdata", rdata, m_rdata);
            if (exp_req) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", mem_we, exp_we);
                check("mem_be", mem_be, exp_be);
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    // Activity counters and snapshot of the acknowledged beat, for literal checks.
    int          stall_cycles = 0;
    int          req_cycles   = 0;
    logic [31:0] last_addr  = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_be    = '0;

    always @(negedge clk) begin
        if (stall)   stall_cycles++;
        if (mem_req) req_cycles++;
        if (mem_req && mem_ack) begin
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
            last_be    = mem_be;
        end
    end

    function automatic logic m_is_load(input logic [5:0] op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    function automatic logic m_is_store(input logic [5:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic m_misaligned(input logic [5:0] op, input logic [31:0] a);
        if (op == LW || op == SW) return (a % 4) != 0;
        if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] wd);
        if (op == SB) return (wd & 32'hFF) * 32'h01010101;
        if (op == SH) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (op)
            LB:      return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            LBU:     return b;
            LH:      return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        exp_stall = 0; exp_req = 0; exp_rvalid = 0; exp_aerr = 0; exp_berr = 0;
    endtask

    // ack_at: BUSY cycle (1-based) on which mem_ack is raised; 0 = never.
    task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] b, input int ack_at, input logic [31:0] rd);
        logic hnd, mis, ld, acked;
        int   nb;
        hnd   = m_is_load(op) || m_is_store(op);
        mis   = hnd && m_misaligned(op, a);
        ld    = m_is_load(op);
        acked = (ack_at >= 1) && (ack_at <= TIMEOUT);
        nb    = acked ? ack_at : TIMEOUT;

        step();
        req_valid = 1; OP = op; addr = a; wdata = wd; be = b; mem_ack = 0;
        clear_exp();
        exp_stall = hnd && !mis;
        if (!hnd || mis) begin
            step();
            req_valid = 0;
            clear_exp();
            exp_aerr = mis;
            step();
            clear_exp();
            return;
        end

        for (int k = 1; k <= nb; k++) begin
            step();
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? rd : 32'h5A5AC3C3;
            clear_exp();
            exp_stall = 1; exp_req = 1;
            exp_addr  = a & 32'hFFFFFFFC;
            exp_we    = !ld;
            exp_be    = ld ? 4'hF : b;
            exp_wdata = m_wdata(op, wd);
        end

        // Response cycle: request still presented but must not be taken.
        step();
        mem_ack = 0;
        clear_exp();
        exp_rvalid = ld && acked;
        exp_berr   = !acked;
        if (!acked)  m_rdata = 0;
        else if (ld) m_rdata = m_load(op, a, rd);

        step();
        req_valid = 0;
        clear_exp();
    endtask

    int s0, r0;

    initial begin
        rst = 1; req_valid = 0; OP = 0; addr = 0; wdata = 0; be = 0;
        mem_ack = 0; mem_rdata = 0; m_rdata = 0;
        exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_be = 0;
        clear_exp();
        #3;
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_rdata", rdata, 0);
        check("rst_pulses", {rdata_valid, addr_err, bus_err}, 0);
        @(posedge clk); #3;
        rst = 0;
        chk_en = 1;

        s0 = stall_cycles;
        run_txn(SW, 32'h100, 32'hDEADBEEF, 4'b1111, 1, 0);
        check("sw_stall_cycles", stall_cycles - s0, 2);
        check("sw_mem_addr", last_addr, 32'h100);

        s0 = stall_cycles;
        run_txn(SB, 32'h203, 32'h000000A5, 4'b1000, 3, 0);
        check("sb_stall_cycles", stall_cycles - s0, 4);
        check("sb_mem_wdata", last_wdata, 32'hA5A5A5A5);
        check("sb_mem_addr", last_addr, 32'h200);
        check("sb_mem_be", last_be, 4'b1000);

        run_txn(LB, 32'h7, 0, 0, 2, 32'h80FF0000);
        check("lb_rdata", rdata, 32'hFFFFFF80);
        run_txn(LBU, 32'h7, 0, 0, 1, 32'h80FF0000);
        check("lbu_rdata", rdata, 32'h00000080);
        run_txn(LHU, 32'h6, 0, 0, 1, 32'h80FF0000);
        check("lhu_rdata", rdata, 32'h000080FF);
        run_txn(LH, 32'h6, 0, 0, 2, 32'h80FF0000);
        check("lh_rdata", rdata, 32'hFFFF80FF);
        run_txn(LW, 32'h8, 0, 0, 1, 32'hCAFEF00D);
        check("lw_rdata", rdata, 32'hCAFEF00D);

        r0 = req_cycles;
        run_txn(LW, 32'h102, 0, 0, 1, 0);
        run_txn(SH, 32'h3, 32'h1234, 4'b0011, 1, 0);
        run_txn(ADDI, 32'h10, 0, 0, 1, 0);
        check("misalign_no_req", req_cycles - r0, 0);

        run_txn(SH, 32'h2, 32'h1234BEEF, 4'b1100, 2, 0);
        check("sh_mem_wdata", last_wdata, 32'hBEEFBEEF);
        run_txn(SB, 32'h11, 32'h77, 4'b0000, 1, 0);
        check("sb_be0_mem_be", last_be, 4'b0000);

        r0 = req_cycles;
        run_txn(LW, 32'h20, 0, 0, 0, 0);
        check("timeout_req_cycles", req_cycles - r0, TIMEOUT);
        check("timeout_rdata", rdata, 0);

        run_txn(LW, 32'h24, 0, 0, TIMEOUT, 32'h13572468);
        check("ack_on_timeout_rdata", rdata, 32'h13572468);

        // Asynchronous reset in the middle of a BUSY phase.
        chk_en = 0;
        step();
        req_valid = 1; OP = LW; addr = 32'h40;
        step(); step(); step();
        #2;
        check("pre_rst_mem_req", mem_req, 1);
        rst = 1;
        #1;
        check("async_rst_mem_req", mem_req, 0);
        check("async_rst_stall", stall, 0);
        req_valid = 0;
        step(); step();
        #2;
        rst = 0;
        m_rdata = 0;
        clear_exp();
        chk_en = 1;
        run_txn(LW, 32'h44, 0, 0, 2, 32'h0BADCAFE);
        check("post_rst_lw_rdata", rdata, 32'h0BADCAFE);

        step();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
